// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle magnitude comparator. It compares a wide operand pair SLICE bits
// per cycle, starting at the least significant slice. A less/equal/greater
// cascade state is carried from one cycle to the next. Because higher slices
// are processed later, they override the verdict of lower slices. An external
// {l,e,g} seed initialises the cascade, so several instances can be chained,
// or the block can follow a parallel comparator stage.
//
// Optional feature macro: COMPARATOR_SIGNED_EN
//   defined   : operands are two's complement. The MSB of each operand is
//               inverted before slicing.
//   undefined : unsigned compare; no inversion logic is built.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        compare request, accepted only while ready=1
//   a, b         operands, sampled on the accepting edge
//   l, e, g      cascade seed, sampled on the accepting edge
//   abort        synchronous cancel of an in-flight compare
//   ready        high in IDLE
//   busy         high in RUN
//   done         one-cycle pulse, result valid
//   lt, et, gt   registered one-hot result, held until the next done
//
// States
//   state  | meaning
//   IDLE   | waiting for start, ready=1
//   RUN    | one slice per cycle, LSB first, busy=1
//   DONE   | result just loaded, done=1 for one cycle
// -----------------------------------------------------------------------------
module seq_magnitude_comparator #(
  parameter int WIDTH = 9,
  parameter int SLICE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             et,
  output logic             gt
);

  localparam int N  = (WIDTH + SLICE - 1) / SLICE;
  localparam int PW = N * SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // cascade encoding {less, equal, greater}
  localparam logic [2:0] C_L = 3'b100;
  localparam logic [2:0] C_E = 3'b010;
  localparam logic [2:0] C_G = 3'b001;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    a_sh;
  logic [PW-1:0]    b_sh;
  logic [2:0]       cas;
  logic [2:0]       cas_nxt;
  logic [2:0]       seed;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;

`ifdef COMPARATOR_SIGNED_EN
  // Flipping the sign bit maps two's complement onto offset binary. After that,
  // an unsigned slice compare orders the operands correctly.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  assign a_in = a ^ MSB_MASK;
  assign b_in = b ^ MSB_MASK;
`else
  assign a_in = a;
  assign b_in = b;
`endif

  // Any seed that is not exactly one-hot is treated as "equal".
  always_comb begin
    seed = {l, e, g};
    if (!((seed == C_L) || (seed == C_E) || (seed == C_G))) begin
      seed = C_E;
    end
  end

  // The operands shift right every RUN cycle, so the current slice is always
  // in the low bits of the shift registers.
  assign a_s = a_sh[SLICE-1:0];
  assign b_s = b_sh[SLICE-1:0];

  always_comb begin
    cas_nxt = cas;
    if (a_s > b_s) begin
      cas_nxt = C_G;
    end else if (a_s < b_s) begin
      cas_nxt = C_L;
    end
  end

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      cas   <= C_E;
      lt    <= 1'b0;
      et    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // start wins over a simultaneous abort
          if (start) begin
            a_sh  <= PW'(a_in);
            b_sh  <= PW'(b_in);
            cas   <= seed;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cas  <= cas_nxt;
            a_sh <= a_sh >> SLICE;
            b_sh <= b_sh >> SLICE;
            if (cnt == LAST) begin
              state        <= S_DONE;
              cnt          <= '0;
              {lt, et, gt} <= cas_nxt;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// Testbench for seq_magnitude_comparator (WIDTH=9, SLICE=3).
// Stimulus pushes the expected result and completion cycle into a scoreboard.
// A monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 9;
  localparam int N     = 3;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_ET = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             l, e, g;
  logic             abort;
  logic             ready, busy, done;
  logic             lt, et, gt;

  typedef struct {
    logic [2:0] res;
    int         cyc;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic [2:0] last_res = 3'b000;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .SLICE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .l     (l),
    .e     (e),
    .g     (g),
    .abort (abort),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .et    (et),
    .gt    (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "global timeout");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done cyc=%0d got={lt,et,gt}=%b", cyc, {lt, et, gt});
      end else begin
        exp_t x;
        x = sb.pop_front();
        tests++;
        if ({lt, et, gt} !== x.res) begin
          fails++;
          $display("FAIL %s result got=%b exp=%b", x.name, {lt, et, gt}, x.res);
        end
        tests++;
        if (cyc != x.cyc) begin
          fails++;
          $display("FAIL %s latency done_cyc got=%0d exp=%0d", x.name, cyc, x.cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Waits for ready and presents one start cycle. It returns at the negedge
  // after the accepting edge. c is the cycle count when start was driven.
  task automatic drive_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             input logic [2:0] sd, output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout waited=%0d exp=ready", n);
    end
    a     = av;
    b     = bv;
    {l, e, g} = sd;
    start = 1'b1;
    c     = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input string nm, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [2:0] sd, input logic [2:0] exp_u, input logic [2:0] exp_s);
    int   c;
    exp_t x;
    drive_start(av, bv, sd, c);
`ifdef COMPARATOR_SIGNED_EN
    x.res = exp_s;
`else
    x.res = exp_u;
`endif
    x.cyc    = c + 1 + N;
    x.name   = nm;
    last_res = x.res;
    sb.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a = '0;
    b = '0;
    {l, e, g} = 3'b000;
    repeat (2) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", {lt, et, gt}, 3'b000);
    rst_n = 1'b1;

    // directed vectors: name, a, b, seed {l,e,g}, expected unsigned, expected signed
    issue("eq_seed_e",    9'h001, 9'h001, 3'b010, R_ET, R_ET);
    issue("eq_seed_l",    9'h001, 9'h001, 3'b100, R_LT, R_LT);
    issue("eq_seed_g",    9'h001, 9'h001, 3'b001, R_GT, R_GT);
    issue("gt_over_l",    9'h002, 9'h001, 3'b100, R_GT, R_GT);
    issue("lt_over_g",    9'h001, 9'h002, 3'b001, R_LT, R_LT);
    issue("msb_100_0ff",  9'h100, 9'h0FF, 3'b010, R_GT, R_LT);
    issue("low_slice_lt", 9'h1C0, 9'h1C1, 3'b010, R_LT, R_LT);
    issue("m1_vs_0",      9'h1FF, 9'h000, 3'b010, R_GT, R_LT);
    issue("m4_vs_3",      9'h1FC, 9'h003, 3'b010, R_GT, R_LT);
    issue("seed_000",     9'h055, 9'h055, 3'b000, R_ET, R_ET);
    issue("seed_111",     9'h0AA, 9'h0AA, 3'b111, R_ET, R_ET);
    drain();
    check("hold_after_done", {lt, et, gt}, last_res);

    // abort two cycles into RUN: no done, result held, ready next cycle
    drive_start(9'h002, 9'h001, 3'b010, c);
    check("abort_busy", busy, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_busy_low", busy, 0);
    check("abort_result_held", {lt, et, gt}, last_res);
    repeat (N + 2) @(negedge clk);
    check("abort_result_still", {lt, et, gt}, last_res);

    // start during RUN is ignored; the first result is unaffected
    issue("start_in_run", 9'h0AA, 9'h0AB, 3'b010, R_LT, R_LT);
    a = 9'h1FF;
    b = 9'h000;
    {l, e, g} = 3'b001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    check("no_extra_done", sb.size(), 0);

    // start together with abort in IDLE: start wins
    @(negedge clk);
    a = 9'h003;
    b = 9'h004;
    {l, e, g} = 3'b010;
    start = 1'b1;
    abort = 1'b1;
    begin
      exp_t x;
      x.res = R_LT;
      x.cyc = cyc + 1 + N;
      x.name = "start_abort_idle";
      last_res = R_LT;
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    drain();

    // asynchronous reset mid-RUN
    drive_start(9'h1FF, 9'h000, 3'b010, c);
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {lt, et, gt}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    check("rst_no_done_result", {lt, et, gt}, 3'b000);
    issue("after_reset", 9'h010, 9'h008, 3'b010, R_GT, R_GT);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
